// File: rtl/rojobot_pkg.sv
// Shared constants for the Rojobot-to-MIPSfpga update bridge.
// Holds the FSM state encoding and the bot_info word width.
// Also holds the field layout of bot_info: {LocX, LocY, Sensors, BotInfo}.
package rojobot_pkg;

    localparam int BOT_INFO_W = 32;

    // Field offsets inside the 32-bit bot info word (each field is 8 bits wide).
    localparam int FIELD_W         = 8;
    localparam int LOCX_LSB        = 24;
    localparam int LOCY_LSB        = 16;
    localparam int SENSORS_LSB     = 8;
    localparam int BOTINFO_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/rojobot_update_bridge_sync.sv
// Synchroniser chain plus a registered rising-edge detector for an async strobe.
// Latency: input first sampled at edge N -> evt high during the cycle after edge N+SYNC_STAGES.
// No backpressure; evt is a one-cycle pulse per rising edge of the synchronised level.
// Ports: clk, rst_n (async active-low), async_in (raw strobe), evt (one-cycle event).
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic evt
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // fill_q marks when the chain holds only post-reset samples. The detector
    // arms only after it has seen the synchronised level low, so a strobe that
    // was already high across a reset release is not reported as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            evt     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
            evt     <= armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/rojobot_update_bridge.sv
// Bridges Rojobot update strobes into the MIPSfpga clock domain with snapshot and pending flag.
// Latency: strobe first sampled at edge N -> snapshot and bot_update_sync valid after edge N+SYNC_STAGES+1.
// Software acks by holding int_ack; updates arriving while pending are counted as overruns.
// Ports: SI_ClkIn/SI_Reset_N clock and async reset; upd_sysregs async strobe; bot_info_in data word;
//        int_ack level ack; bot_update_sync pending flag; bot_info_out snapshot; update_cnt, overrun_cnt.
module rojobot_update_bridge
    import rojobot_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16,
    parameter int OVR_W         = 8,
    parameter bit OVERWRITE_NEW = 1'b1
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset_N,
    input  logic                  upd_sysregs,
    input  logic [BOT_INFO_W-1:0] bot_info_in,
    input  logic                  int_ack,
    output logic                  bot_update_sync,
    output logic [BOT_INFO_W-1:0] bot_info_out,
    output logic [CNT_W-1:0]      update_cnt,
    output logic [OVR_W-1:0]      overrun_cnt
);

    state_t state_q, state_d;
    logic   queued_q, queued_d;
    logic   upd_evt;
    logic   capture;
    logic   inc_upd;
    logic   inc_ovr;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (SI_ClkIn),
        .rst_n    (SI_Reset_N),
        .async_in (upd_sysregs),
        .evt      (upd_evt)
    );

    always_comb begin
        state_d  = state_q;
        queued_d = queued_q;
        capture  = 1'b0;
        inc_upd  = 1'b0;
        inc_ovr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (upd_evt) begin
                    capture = 1'b1;
                    inc_upd = 1'b1;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (int_ack) begin
                    // Ack wins over a simultaneous event: the event is queued, not an overrun.
                    state_d = ST_HOLDOFF;
                    if (upd_evt) begin
                        capture  = 1'b1;
                        inc_upd  = 1'b1;
                        queued_d = 1'b1;
                    end
                end else if (upd_evt) begin
                    inc_ovr = 1'b1;
                    inc_upd = 1'b1;
                    capture = OVERWRITE_NEW;
                end
            end
            ST_HOLDOFF: begin
                if (upd_evt) begin
                    capture  = 1'b1;
                    inc_upd  = 1'b1;
                    queued_d = 1'b1;
                end
                if (!int_ack) begin
                    // An event landing in the same cycle the ack drops must not be lost.
                    if (queued_q || upd_evt) begin
                        state_d  = ST_PENDING;
                        queued_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                queued_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_q         <= ST_IDLE;
            queued_q        <= 1'b0;
            bot_update_sync <= 1'b0;
            bot_info_out    <= '0;
            update_cnt      <= '0;
            overrun_cnt     <= '0;
        end else begin
            state_q         <= state_d;
            queued_q        <= queued_d;
            bot_update_sync <= (state_d == ST_PENDING);
            if (capture) begin
                bot_info_out <= bot_info_in;
            end
            if (inc_upd) begin
                update_cnt <= update_cnt + CNT_W'(1);
            end
            if (inc_ovr && (overrun_cnt != {OVR_W{1'b1}})) begin
                overrun_cnt <= overrun_cnt + OVR_W'(1);
            end
        end
    end

endmodule
